// File: rtl/ifetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface ifetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, fetches over imem req/ack, holds each word for one
// execute window, then follows pcsrc; a misaligned taken target halts the core.
module ifetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            reset_n,
    ifetch_if.master        imem,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4,
    output logic            instr_valid,
    output logic            misalign_err,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [31:0]     instret_q, instret_d;

    logic            fetch_done;
    logic            commit;

    // req_q is low straight out of reset, so an ack in that first REQ cycle is ignored
    assign fetch_done = (state_q == S_REQ) && req_q && imem.imem_ack;
    assign commit     = (state_q == S_EXEC) && !stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        req_d     = 1'b0;
        valid_d   = 1'b0;
        err_d     = err_q;
        instret_d = instret_q;
        case (state_q)
            S_REQ: begin
                if (fetch_done) begin
                    state_d = S_EXEC;
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                end else begin
                    req_d   = 1'b1;
                    instr_d = NOP_WORD;
                end
            end
            S_EXEC: begin
                if (!commit) begin
                    valid_d = 1'b1;
                end else begin
                    instret_d = instret_q + 32'd1;
                    instr_d   = NOP_WORD;
                    if (pcsrc) begin
                        pc_d = branch_target;
                        // the faulting instruction still retires before the halt
                        if (branch_target[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            state_d = S_REQ;
                            req_d   = 1'b1;
                        end
                    end else begin
                        pc_d    = pcplus4;
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            S_HALT: begin
                instr_d = NOP_WORD;
            end
            default: begin
                state_d = S_HALT;
                instr_d = NOP_WORD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign op             = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7b5       = instr_q[30];
    assign pc             = pc_q;
    assign pcplus4        = pc_q + XLEN'(4);
    assign instr_valid    = valid_q;
    assign misalign_err   = err_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: cycle model of the fetch rules checked every
// negedge, plus literal expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        stall = 1'b0;

    logic [31:0] instr, pc, pcplus4, instret;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, instr_valid, misalign_err;

    logic [31:0] w_instr, w_pc, w_pcplus4, w_instret;
    logic [6:0]  w_op;
    logic [2:0]  w_funct3;
    logic        w_funct7b5, w_instr_valid, w_misalign_err;

    int vectors = 0;
    int miscompares = 0;

    ifetch_if #(.XLEN(32)) inf ();
    ifetch_if #(.XLEN(32)) inf_w ();

    always #5 clk = ~clk;

    ifetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .imem(inf.master),
        .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
        .instr(instr), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .pc(pc), .pcplus4(pcplus4), .instr_valid(instr_valid),
        .misalign_err(misalign_err), .instret(instret)
    );

    // Second instance exercising the top-of-address-space reset vector
    ifetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset_n(reset_n), .imem(inf_w.master),
        .pcsrc(1'b0), .branch_target(32'd0), .stall(1'b0),
        .instr(w_instr), .op(w_op), .funct3(w_funct3), .funct7b5(w_funct7b5),
        .pc(w_pc), .pcplus4(w_pcplus4), .instr_valid(w_instr_valid),
        .misalign_err(w_misalign_err), .instret(w_instret)
    );
    assign inf_w.imem_ack   = inf_w.imem_req;
    assign inf_w.imem_rdata = NOP;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction memory: answers after mem_wait idle cycles; spurious acks on demand
    logic [31:0] prog [16];
    int          mem_wait = 0;
    bit          spurious = 1'b0;
    initial begin
        inf.imem_ack   = 1'b0;
        inf.imem_rdata = 32'd0;
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h4020_8133;
        prog[2] = 32'h0020_9463;
        prog[3] = 32'h0000_a183;
        for (int i = 4; i < 16; i++) prog[i] = NOP + (i << 7);
    end
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (inf.imem_req) begin
                if (wcnt >= mem_wait) begin
                    inf.imem_ack   = 1'b1;
                    inf.imem_rdata = prog[inf.imem_addr[5:2]];
                    wcnt = 0;
                end else begin
                    inf.imem_ack   = 1'b0;
                    inf.imem_rdata = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                inf.imem_ack   = spurious;
                inf.imem_rdata = 32'hBAD0_0001;
                wcnt = 0;
            end
        end
    end

    // Model: fetching until an accepted ack, holding the word until a non-stalled
    // cycle retires it, halted forever after a misaligned taken target.
    bit          m_req, m_hold, m_halt, m_err;
    logic [31:0] m_pc, m_word, m_ret;
    initial begin
        m_req = 0; m_hold = 0; m_halt = 0; m_err = 0;
        m_pc = 32'd0; m_word = NOP; m_ret = 32'd0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_req = 0; m_hold = 0; m_halt = 0; m_err = 0;
                m_pc = 32'd0; m_word = NOP; m_ret = 32'd0;
            end else if (m_halt) begin
                m_req = 0;
            end else if (m_hold) begin
                if (!stall) begin
                    m_ret  = m_ret + 1;
                    m_hold = 0;
                    if (pcsrc) begin
                        m_pc = branch_target;
                        if (branch_target % 4 != 0) begin
                            m_halt = 1; m_err = 1;
                        end else m_req = 1;
                    end else begin
                        m_pc  = m_pc + 4;
                        m_req = 1;
                    end
                end
            end else if (m_req && inf.imem_ack) begin
                m_word = inf.imem_rdata;
                m_hold = 1;
                m_req  = 0;
            end else begin
                m_req = 1;
            end
        end
    end

    initial begin
        logic [31:0] ei;
        forever begin
            @(negedge clk);
            ei = m_hold ? m_word : NOP;
            chk("imem_req",     32'(inf.imem_req), 32'(m_req));
            chk("imem_addr",    inf.imem_addr, m_pc);
            chk("instr",        instr, ei);
            chk("op",           32'(op), 32'(ei[6:0]));
            chk("funct3",       32'(funct3), 32'(ei[14:12]));
            chk("funct7b5",     32'(funct7b5), 32'(ei[30]));
            chk("pc",           pc, m_pc);
            chk("pcplus4",      pcplus4, m_pc + 32'd4);
            chk("instr_valid",  32'(instr_valid), 32'(m_hold));
            chk("misalign_err", 32'(misalign_err), 32'(m_err));
            chk("instret",      instret, m_ret);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #4;
    endtask

    task automatic wait_valid(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            wait_cyc(1);
            if (instr_valid) seen = 1'b1;
        end
        chk({nm, "_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000ns");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bit done;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_req", 32'(inf.imem_req), 32'd0);
        chk("rst_instr", instr, NOP);
        reset_n = 1'b1;

        // Zero-wait sequential fetch
        wait_cyc(1);
        chk("t1_req", 32'(inf.imem_req), 32'd1);
        chk("t1_addr", inf.imem_addr, 32'h0);
        chk("w_addr0", inf_w.imem_addr, 32'hFFFF_FFFC);
        chk("w_pcplus4", w_pcplus4, 32'h0000_0000);
        wait_cyc(1);
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_op", 32'(op), 32'h13);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_pc", pc, 32'h0);
        wait_cyc(1);
        chk("t1_addr4", inf.imem_addr, 32'h4);
        chk("t1_instret", instret, 32'd1);
        chk("w_addr1", inf_w.imem_addr, 32'h0000_0000);
        chk("w_instret", w_instret, 32'd1);

        // Three wait states on the fetch of address 8
        mem_wait = 3;
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            wait_cyc(1);
            if (instr_valid && pc == 32'h8) done = 1'b1;
            else if (inf.imem_req && inf.imem_addr == 32'h8) cnt++;
        end
        chk("t2_reached", 32'(done), 32'd1);
        chk("t2_req_cycles", 32'(cnt), 32'd4);
        chk("t2_funct3", 32'(funct3), 32'd1);
        wait_cyc(1);
        chk("t2_instret", instret, 32'd3);
        chk("t2_addr", inf.imem_addr, 32'hC);
        mem_wait = 0;

        // Two stall cycles, then a taken branch to 0x40
        wait_valid("t3_valid");
        chk("t3_pc", pc, 32'hC);
        stall = 1'b1; pcsrc = 1'b1; branch_target = 32'h40;
        for (int i = 0; i < 2; i++) begin
            wait_cyc(1);
            chk("t3_stall_pc", pc, 32'hC);
            chk("t3_stall_instr", instr, 32'h0000_a183);
            chk("t3_stall_instret", instret, 32'd3);
        end
        stall = 1'b0;
        wait_cyc(1);
        chk("t3_redirect", inf.imem_addr, 32'h40);
        chk("t3_instret", instret, 32'd4);
        pcsrc = 1'b0;

        // Misaligned taken target halts
        wait_valid("t4_valid");
        pcsrc = 1'b1; branch_target = 32'h42;
        wait_cyc(1);
        chk("t4_err", 32'(misalign_err), 32'd1);
        chk("t4_pc", pc, 32'h42);
        chk("t4_instret", instret, 32'd5);
        pcsrc = 1'b0; spurious = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            chk("t4_halt_req", 32'(inf.imem_req), 32'd0);
            chk("t4_halt_instret", instret, 32'd5);
        end
        reset_n = 1'b0;
        #1;
        chk("t4_rst_err", 32'(misalign_err), 32'd0);
        chk("t4_rst_instret", instret, 32'd0);
        chk("t4_rst_pc", pc, 32'h0);
        wait_cyc(2);
        reset_n = 1'b1; spurious = 1'b0;

        // Reset mid-wait at 0x100; a late ack during reset is ignored
        wait_valid("t5_valid");
        pcsrc = 1'b1; branch_target = 32'h100; mem_wait = 10;
        wait_cyc(1);
        chk("t5_addr", inf.imem_addr, 32'h100);
        pcsrc = 1'b0;
        wait_cyc(2);
        chk("t5_waiting", 32'(inf.imem_req), 32'd1);
        reset_n = 1'b0; spurious = 1'b1;
        #1;
        chk("t5_async_req", 32'(inf.imem_req), 32'd0);
        chk("t5_async_pc", pc, 32'h0);
        wait_cyc(2);
        chk("t5_rst_valid", 32'(instr_valid), 32'd0);
        reset_n = 1'b1; spurious = 1'b0; mem_wait = 0;
        wait_cyc(1);
        chk("t5_first_req", 32'(inf.imem_req), 32'd1);
        chk("t5_first_addr", inf.imem_addr, 32'h0);
        chk("t5_first_valid", 32'(instr_valid), 32'd0);
        wait_cyc(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
